ahb_mtx_out_arb: RTL
====================

AHB_MTX_OUT_ARB -- requirements
Module: ahb_mtx_out_arb

Interface
REQ-001 SHALL have parameter NUM_IN, default 3, meaning the number of input stages sharing this output port (fixed at 3; other values unsupported).
REQ-002 SHALL have ports:
- HCLK  in  1  AHB clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- sel_op  in  3  bit n = decoder n requests this port.
- trans_op0/1/2  in  2 each  HTRANS of input n.
- burst_op0/1/2  in  3 each  HBURST of input n.
- mastlock_op0/1/2  in  1 each  HMASTLOCK of input n.
- HREADYM  in  1  HREADY of the output port.
- addr_in_port  out  2  registered address-phase owner.
- no_port  out  1  registered; 1 = no owner.
- active_op  out  3  one-hot active feedback to decoders.
- HSELM  out  1  output-port select.
- data_in_port  out  2  data-phase owner.
- data_no_port  out  1  data phase has no owner.
REQ-003 Reset SHALL be HRESETn, asynchronous, active-low; clock SHALL be HCLK; all state SHALL update on posedge HCLK only.

Function
REQ-004 Registered state: addr_in_port, no_port, last_grant[1:0], beat_cnt[3:0], data_in_port, data_no_port.
REQ-005 active_op[n] SHALL be 1 iff no_port=0 and addr_in_port=n; HSELM SHALL equal ~no_port & sel_op[addr_in_port].
REQ-006 Grant registers (addr_in_port, no_port, last_grant) SHALL update only on edges with HREADYM=1; with HREADYM=0 all grant, counter and data registers SHALL hold.
REQ-007 Accepted beat: an edge with HREADYM=1, no_port=0, sel_op[owner]=1 and trans_op[owner] = NONSEQ (2'b10) or SEQ (2'b11).
REQ-008 beat_cnt SHALL load on accepted NONSEQ: SINGLE/INCR -> 0, INCR4/WRAP4 -> 3, INCR8/WRAP8 -> 7, INCR16/WRAP16 -> 15.
REQ-009 beat_cnt SHALL decrement on accepted SEQ when nonzero; it SHALL saturate at 0; BUSY or IDLE SHALL leave it unchanged.
REQ-010 Hold condition = no_port=0 and sel_op[owner]=1 and (mastlock_op[owner]=1 or beat_cnt after this edge's update is nonzero); if set, owner SHALL be kept.
REQ-011 Otherwise, the next owner SHALL be the first requester with sel_op set, searching round-robin from last_grant+1 (mod 3).
REQ-012 On a grant, addr_in_port SHALL take the winner, no_port SHALL clear, and last_grant SHALL take the winner.
REQ-013 With no requester and no hold, no_port SHALL set; addr_in_port and last_grant SHALL hold.
REQ-014 A current owner still requesting with no hold SHALL compete normally; if it is the sole requester it SHALL be re-granted with no gap cycle.
REQ-015 Grant latency: first request to this port with no_port=1 and HREADYM=1 -> active_op asserted the following cycle.
REQ-016 On every edge with HREADYM=1, data_in_port SHALL take addr_in_port and data_no_port SHALL take (no_port | ~sel_op[addr_in_port]).
REQ-017 An INCR burst (count 0) SHALL be rearbitrable after any beat; other requesters can break it, which is legal for a multi-layer matrix.
REQ-018 A locked sequence SHALL retain the port through IDLE beats until mastlock_op[owner] deasserts.

Reset
REQ-019 During and after reset: addr_in_port=2'b00, no_port=1, last_grant=2'b10 (input 0 wins first), beat_cnt=0, data_in_port=2'b00, data_no_port=1, active_op=3'b000, HSELM=0.
REQ-020 Reset assertion mid-burst SHALL return all state to REQ-019 values immediately, without waiting for HCLK.

Verification
REQ-021 Reset release; sel_op=3'b111, HREADYM=1 -> cycle+1: addr_in_port=0, active_op=3'b001.
REQ-022 Input 1 only, NONSEQ INCR4 then 3 SEQ; sel_op=3'b111 throughout -> input 1 holds all 4 beats; next owner is input 2, then input 0.
REQ-023 Owner in INCR8 with HREADYM low 3 cycles mid-burst -> beat_cnt, addr_in_port and data_in_port frozen; burst completes 8 beats without owner change.
REQ-024 Input 2 with mastlock=1 issues SINGLE, IDLE, SINGLE; input 0 requesting -> input 2 retained until mastlock drops, then input 0 granted next edge.
REQ-025 All sel_op drop after a SINGLE -> no_port=1, HSELM=0, and data_no_port=1 one HREADYM edge later; addr_in_port unchanged.
REQ-026 HRESETn asserted asynchronously mid-INCR16 at beat 5 -> all outputs at REQ-019 values before the next HCLK edge.

Source files
------------

// File: rtl/ahb_mtx_out_arb.sv
// ---------------------------------------------------------------------------
// ahb_mtx_out_arb
//
// Output-port arbiter for a multi-layer AHB matrix. Three input stages
// (decoders) compete for a single output port. The arbiter picks an
// address-phase owner round-robin, and keeps that owner for the rest of a
// fixed-length burst or for as long as the owner holds HMASTLOCK. It also
// tracks which input owns the data phase.
//
// Handshake: the output port's HREADYM is the only flow control. A register
// updates only on an HCLK edge where HREADYM=1. With HREADYM=0 every grant,
// beat-counter and data-phase register holds its value.
//
// Ports
//   HCLK                  in   AHB clock
//   HRESETn               in   asynchronous active-low reset
//   sel_op[2:0]           in   bit n: decoder n requests this port
//   trans_op0/1/2[1:0]    in   HTRANS of input n
//   burst_op0/1/2[2:0]    in   HBURST of input n
//   mastlock_op0/1/2      in   HMASTLOCK of input n
//   HREADYM               in   HREADY of the output port
//   addr_in_port[1:0]     out  registered address-phase owner
//   no_port               out  registered, 1 = no owner
//   active_op[2:0]        out  one-hot active feedback to the decoders
//   HSELM                 out  output-port select
//   data_in_port[1:0]     out  data-phase owner
//   data_no_port          out  data phase has no owner
// ---------------------------------------------------------------------------
module ahb_mtx_out_arb #(
  parameter int NUM_IN = 3
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [NUM_IN-1:0] sel_op,
  input  logic [1:0]        trans_op0,
  input  logic [1:0]        trans_op1,
  input  logic [1:0]        trans_op2,
  input  logic [2:0]        burst_op0,
  input  logic [2:0]        burst_op1,
  input  logic [2:0]        burst_op2,
  input  logic              mastlock_op0,
  input  logic              mastlock_op1,
  input  logic              mastlock_op2,
  input  logic              HREADYM,
  output logic [1:0]        addr_in_port,
  output logic              no_port,
  output logic [NUM_IN-1:0] active_op,
  output logic              HSELM,
  output logic [1:0]        data_in_port,
  output logic              data_no_port
);

  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  logic [1:0] r_addr;
  logic       r_no;
  logic [1:0] r_last;
  logic [3:0] r_cnt;
  logic [1:0] r_data;
  logic       r_dno;

  logic       w_sel_own;
  logic [1:0] w_trans_own;
  logic [2:0] w_burst_own;
  logic       w_lock_own;
  logic       w_accept;
  logic [3:0] w_cnt_next;
  logic       w_hold;
  logic       w_found;
  logic [1:0] w_winner;
  logic [NUM_IN-1:0] w_active;

  // Signals of the current address-phase owner. The owner code never
  // reaches 3; the default arm only keeps the mux complete.
  always_comb begin
    w_sel_own   = 1'b0;
    w_trans_own = 2'b00;
    w_burst_own = 3'b000;
    w_lock_own  = 1'b0;
    case (r_addr)
      2'd0: begin
        w_sel_own   = sel_op[0];
        w_trans_own = trans_op0;
        w_burst_own = burst_op0;
        w_lock_own  = mastlock_op0;
      end
      2'd1: begin
        w_sel_own   = sel_op[1];
        w_trans_own = trans_op1;
        w_burst_own = burst_op1;
        w_lock_own  = mastlock_op1;
      end
      2'd2: begin
        w_sel_own   = sel_op[2];
        w_trans_own = trans_op2;
        w_burst_own = burst_op2;
        w_lock_own  = mastlock_op2;
      end
      default: begin
        w_sel_own   = 1'b0;
        w_trans_own = 2'b00;
        w_burst_own = 3'b000;
        w_lock_own  = 1'b0;
      end
    endcase
  end

  // A beat counts only when the owner really drives NONSEQ or SEQ to us.
  assign w_accept = HREADYM & ~r_no & w_sel_own & w_trans_own[1];

  // Remaining beats after this one. INCR (undefined length) loads 0, so it
  // can be rearbitrated after any beat.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_accept) begin
      if (w_trans_own == TRANS_NONSEQ) begin
        case (w_burst_own)
          3'b010, 3'b011: w_cnt_next = 4'd3;
          3'b100, 3'b101: w_cnt_next = 4'd7;
          3'b110, 3'b111: w_cnt_next = 4'd15;
          default:        w_cnt_next = 4'd0;
        endcase
      end else if (r_cnt != 4'd0) begin
        w_cnt_next = r_cnt - 4'd1;
      end
    end
  end

  assign w_hold = ~r_no & w_sel_own & (w_lock_own | (w_cnt_next != 4'd0));

  // Round-robin search, starting with the input after the last winner.
  always_comb begin
    w_found  = |sel_op;
    w_winner = r_addr;
    case (r_last)
      2'd0: begin
        if (sel_op[1])      w_winner = 2'd1;
        else if (sel_op[2]) w_winner = 2'd2;
        else if (sel_op[0]) w_winner = 2'd0;
      end
      2'd1: begin
        if (sel_op[2])      w_winner = 2'd2;
        else if (sel_op[0]) w_winner = 2'd0;
        else if (sel_op[1]) w_winner = 2'd1;
      end
      default: begin
        if (sel_op[0])      w_winner = 2'd0;
        else if (sel_op[1]) w_winner = 2'd1;
        else if (sel_op[2]) w_winner = 2'd2;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr <= 2'b00;
      r_no   <= 1'b1;
      r_last <= 2'b10;
      r_cnt  <= 4'd0;
      r_data <= 2'b00;
      r_dno  <= 1'b1;
    end else if (HREADYM) begin
      r_cnt  <= w_cnt_next;
      r_data <= r_addr;
      r_dno  <= r_no | ~w_sel_own;
      if (!w_hold) begin
        if (w_found) begin
          r_addr <= w_winner;
          r_no   <= 1'b0;
          r_last <= w_winner;
        end else begin
          r_no   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_active = '0;
    if (!r_no) begin
      case (r_addr)
        2'd0:    w_active[0] = 1'b1;
        2'd1:    w_active[1] = 1'b1;
        2'd2:    w_active[2] = 1'b1;
        default: w_active    = '0;
      endcase
    end
  end

  assign addr_in_port = r_addr;
  assign no_port      = r_no;
  assign active_op    = w_active;
  assign HSELM        = ~r_no & w_sel_own;
  assign data_in_port = r_data;
  assign data_no_port = r_dno;

endmodule
